// File: rtl/datapath_bus.sv
// Processor datapath: architectural registers, shared internal bus, ALU and IM/DM front-end.
// Optional sticky error flag is enabled by defining DATAPATH_BUS_ERR_EN.
module datapath_bus #(
    parameter int                 DATA_W   = 16,
    parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        bus_sel,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [15:0]       clr_en,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              z_flag,
    output logic [DATA_W-1:0] ac_out
`ifdef DATAPATH_BUS_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int B_PC = 1;
    localparam int B_AR = 2;
    localparam int B_IR = 3;
    localparam int B_AC = 4;
    localparam int B_R  = 5;
    localparam int B_R4 = 7;
    localparam int B_R3 = 8;
    localparam int B_R2 = 9;
    localparam int B_R1 = 10;
    localparam int B_DM = 11;

    logic [DATA_W-1:0] pc_q, ar_q, ir_q, ac_q, r_q, r1_q, r2_q, r3_q, r4_q;
    logic [DATA_W-1:0] pc_d, ar_d, ir_d, ac_d, r_d, r1_d, r2_d, r3_d, r4_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_res;
    logic              alu_vld;
    logic              ac_evt;

    // Common register update: clear beats bus load beats increment.
    function automatic logic [DATA_W-1:0] reg_next(input logic [DATA_W-1:0] cur,
                                                    input logic clr, input logic ld,
                                                    input logic inc,
                                                    input logic [DATA_W-1:0] bus_v);
        if (clr)      reg_next = '0;
        else if (ld)  reg_next = bus_v;
        else if (inc) reg_next = cur + 1'b1;
        else          reg_next = cur;
    endfunction

    function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            3'd1:    alu_fn = a + b;
            3'd2:    alu_fn = a - b;
            3'd3:    alu_fn = a * b;
            3'd4:    alu_fn = {a[DATA_W-2:0], 1'b0};
            default: alu_fn = a;
        endcase
    endfunction

    always_comb begin
        bus = '0;
        case (bus_sel)
            4'd1:    bus = pc_q;
            4'd2:    bus = ar_q;
            4'd4:    bus = ir_q;
            4'd5:    bus = ac_q;
            4'd6:    bus = r_q;
            4'd7:    bus = r1_q;
            4'd8:    bus = r2_q;
            4'd9:    bus = r3_q;
            4'd10:   bus = r4_q;
            4'd12:   bus = dm_rdata;
            4'd13:   bus = im_rdata;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu_vld = (alu_op >= 3'd1) && (alu_op <= 3'd4);
        alu_res = alu_fn(alu_op, ac_q, r_q);

        pc_d = reg_next(pc_q, clr_en[B_PC], write_en[B_PC], inc_en[B_PC], bus);
        ar_d = reg_next(ar_q, clr_en[B_AR], write_en[B_AR], inc_en[B_AR], bus);
        ir_d = reg_next(ir_q, clr_en[B_IR], write_en[B_IR], inc_en[B_IR], bus);
        r_d  = reg_next(r_q,  clr_en[B_R],  write_en[B_R],  inc_en[B_R],  bus);
        r1_d = reg_next(r1_q, clr_en[B_R1], write_en[B_R1], inc_en[B_R1], bus);
        r2_d = reg_next(r2_q, clr_en[B_R2], write_en[B_R2], inc_en[B_R2], bus);
        r3_d = reg_next(r3_q, clr_en[B_R3], write_en[B_R3], inc_en[B_R3], bus);
        r4_d = reg_next(r4_q, clr_en[B_R4], write_en[B_R4], inc_en[B_R4], bus);

        // ALU result slots between clear and bus load for AC only.
        if (clr_en[B_AC])     ac_d = '0;
        else if (alu_vld)     ac_d = alu_res;
        else                  ac_d = reg_next(ac_q, 1'b0, write_en[B_AC], inc_en[B_AC], bus);

        ac_evt = clr_en[B_AC] | alu_vld | write_en[B_AC] | inc_en[B_AC];
        z_d    = ac_evt ? (ac_d == '0) : z_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RESET;
            ar_q <= '0;
            ir_q <= '0;
            ac_q <= '0;
            r_q  <= '0;
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
            r4_q <= '0;
            z_q  <= 1'b1;
        end else begin
            pc_q <= pc_d;
            ar_q <= ar_d;
            ir_q <= ir_d;
            ac_q <= ac_d;
            r_q  <= r_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
            r4_q <= r4_d;
            z_q  <= z_d;
        end
    end

`ifdef DATAPATH_BUS_ERR_EN
    logic err_q, err_d, sel_undef, bad_wr, bad_alu;

    always_comb begin
        sel_undef = (bus_sel == 4'd3) || (bus_sel == 4'd11) ||
                    (bus_sel == 4'd14) || (bus_sel == 4'd15);
        bad_wr    = sel_undef && ((write_en & 16'h0FBE) != 16'h0000);
        bad_alu   = (alu_op != 3'd0) && (write_en[B_AC] || clr_en[B_AC]);
        err_d     = err_q | bad_wr | bad_alu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif

    assign im_addr  = pc_q;
    assign dm_addr  = ar_q;
    assign dm_wdata = bus;
    assign dm_we    = write_en[B_DM];
    assign z_flag   = z_q;
    assign ac_out   = ac_q;

    // Strobe bits with no register behind them.
    logic unused_strobes;
    assign unused_strobes = ^{write_en[15:12], write_en[6], write_en[0],
                              inc_en[15:11], inc_en[6], inc_en[0],
                              clr_en[15:11], clr_en[6], clr_en[0]};

endmodule

// File: tb/tb_datapath_bus.sv
// Self-checking bench for datapath_bus: directed vector table, corner sequences, random run vs model.
module tb_datapath_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  bus_sel;
    logic [15:0] write_en, inc_en, clr_en;
    logic [2:0]  alu_op;
    logic [15:0] im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata, ac_out;
    logic        dm_we, z_flag;
`ifdef DATAPATH_BUS_ERR_EN
    logic        err;
    logic        merr;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state indexed by strobe bit number (1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1).
    logic [15:0] m [16];
    logic        mz;

    datapath_bus #(.DATA_W(16), .PC_RESET(16'h0010)) dut (
        .clk(clk), .rst(rst), .bus_sel(bus_sel), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
        .im_addr(im_addr), .im_rdata(im_rdata), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .z_flag(z_flag), .ac_out(ac_out)
`ifdef DATAPATH_BUS_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 16'h0000;
        m[1] = 16'h0010;
        mz   = 1'b1;
`ifdef DATAPATH_BUS_ERR_EN
        merr = 1'b0;
`endif
    endtask

    function automatic logic [15:0] mbus(input logic [3:0] sel);
        case (sel)
            4'd1:  return m[1];
            4'd2:  return m[2];
            4'd4:  return m[3];
            4'd5:  return m[4];
            4'd6:  return m[5];
            4'd7:  return m[10];
            4'd8:  return m[9];
            4'd9:  return m[8];
            4'd10: return m[7];
            4'd12: return dm_rdata;
            4'd13: return im_rdata;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] malu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        case (op)
            3'd1: return 16'((x + y) % 65536);
            3'd2: return 16'((x - y + 65536) % 65536);
            3'd3: return 16'((x * y) % 65536);
            3'd4: return 16'((x * 2) % 65536);
            default: return a;
        endcase
    endfunction

    task automatic model_step();
        logic [15:0] b;
        logic [15:0] nx [16];
        int ids [9] = '{1, 2, 3, 4, 5, 7, 8, 9, 10};
        logic alu_ok;
        b      = mbus(bus_sel);
        nx     = m;
        alu_ok = (alu_op >= 3'd1) && (alu_op <= 3'd4);
        foreach (ids[k]) begin
            int i;
            i = ids[k];
            if (clr_en[i])               nx[i] = 16'h0000;
            else if (i == 4 && alu_ok)   nx[i] = malu(alu_op, m[4], m[5]);
            else if (write_en[i])        nx[i] = b;
            else if (inc_en[i])          nx[i] = m[i] + 16'd1;
        end
        if (clr_en[4] || write_en[4] || inc_en[4] || alu_ok) mz = (nx[4] == 16'h0000);
`ifdef DATAPATH_BUS_ERR_EN
        if (((write_en & 16'h0FBE) != 0 && bus_sel inside {4'd3, 4'd11, 4'd14, 4'd15}) ||
            (alu_op != 0 && (write_en[4] || clr_en[4]))) merr = 1'b1;
`endif
        m = nx;
    endtask

    // Called at posedge+1: drive, check bus, clock, check state.
    task automatic cycle(input logic [3:0] sel, input logic [15:0] we, input logic [15:0] inc,
                         input logic [15:0] clr, input logic [2:0] alu,
                         input logic [15:0] im, input logic [15:0] dm);
        bus_sel = sel; write_en = we; inc_en = inc; clr_en = clr; alu_op = alu;
        im_rdata = im; dm_rdata = dm;
        #1;
        chk("bus", dm_wdata, mbus(sel));
        chk("dm_we", dm_we, we[11]);
        @(posedge clk);
        model_step();
        #1;
        chk("pc", im_addr, m[1]);
        chk("ar", dm_addr, m[2]);
        chk("ac", ac_out, m[4]);
        chk("z", z_flag, mz);
`ifdef DATAPATH_BUS_ERR_EN
        chk("err", err, merr);
`endif
    endtask

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] we, inc, clr;
        logic [2:0]  alu;
        logic [15:0] im;
        logic [15:0] pc, ar, ac;
        logic        z;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{4'd13, 16'h0008, 16'h0000, 16'h0000, 3'd0, 16'h0003, 16'h0010, 16'h0000, 16'h0000, 1'b1};
        tbl[1]  = '{4'd0,  16'h0000, 16'h0002, 16'h0000, 3'd0, 16'h0000, 16'h0011, 16'h0000, 16'h0000, 1'b1};
        tbl[2]  = '{4'd13, 16'h0010, 16'h0000, 16'h0000, 3'd0, 16'h1234, 16'h0011, 16'h0000, 16'h1234, 1'b0};
        tbl[3]  = '{4'd5,  16'h0004, 16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h0011, 16'h1234, 16'h1234, 1'b0};
        tbl[4]  = '{4'd13, 16'h0020, 16'h0000, 16'h0000, 3'd0, 16'h0007, 16'h0011, 16'h1234, 16'h1234, 1'b0};
        tbl[5]  = '{4'd13, 16'h0010, 16'h0000, 16'h0000, 3'd0, 16'h0005, 16'h0011, 16'h1234, 16'h0005, 1'b0};
        tbl[6]  = '{4'd0,  16'h0000, 16'h0000, 16'h0000, 3'd2, 16'h0000, 16'h0011, 16'h1234, 16'hFFFE, 1'b0};
        tbl[7]  = '{4'd13, 16'h0010, 16'h0000, 16'h0000, 3'd0, 16'h8001, 16'h0011, 16'h1234, 16'h8001, 1'b0};
        tbl[8]  = '{4'd0,  16'h0000, 16'h0000, 16'h0000, 3'd4, 16'h0000, 16'h0011, 16'h1234, 16'h0002, 1'b0};
        tbl[9]  = '{4'd13, 16'h0030, 16'h0000, 16'h0000, 3'd0, 16'h0100, 16'h0011, 16'h1234, 16'h0100, 1'b0};
        tbl[10] = '{4'd0,  16'h0000, 16'h0000, 16'h0000, 3'd3, 16'h0000, 16'h0011, 16'h1234, 16'h0000, 1'b1};
        tbl[11] = '{4'd13, 16'h0010, 16'h0000, 16'h0000, 3'd0, 16'hFFFF, 16'h0011, 16'h1234, 16'hFFFF, 1'b0};
        tbl[12] = '{4'd0,  16'h0000, 16'h0010, 16'h0000, 3'd0, 16'h0000, 16'h0011, 16'h1234, 16'h0000, 1'b1};
        tbl[13] = '{4'd13, 16'h0002, 16'h0000, 16'h0002, 3'd0, 16'h0055, 16'h0000, 16'h1234, 16'h0000, 1'b1};
        tbl[14] = '{4'd0,  16'h0000, 16'h0000, 16'h0000, 3'd1, 16'h0000, 16'h0000, 16'h1234, 16'h0100, 1'b0};

        // Reset with strobes active: they must be ignored.
        rst = 1'b1; bus_sel = 4'd13; write_en = 16'hFFFF; inc_en = 16'hFFFF; clr_en = 16'h0000;
        alu_op = 3'd1; im_rdata = 16'hABCD; dm_rdata = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", im_addr, 16'h0010);
        chk("rst_ac", ac_out, 16'h0000);
        chk("rst_z", z_flag, 1'b1);
        chk("rst_ar", dm_addr, 16'h0000);
`ifdef DATAPATH_BUS_ERR_EN
        chk("rst_err", err, 1'b0);
`endif
        rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].sel, tbl[i].we, tbl[i].inc, tbl[i].clr, tbl[i].alu, tbl[i].im, 16'h0000);
            chk($sformatf("tbl%0d_pc", i), im_addr, tbl[i].pc);
            chk($sformatf("tbl%0d_ar", i), dm_addr, tbl[i].ar);
            chk($sformatf("tbl%0d_ac", i), ac_out, tbl[i].ac);
            chk($sformatf("tbl%0d_z", i), z_flag, tbl[i].z);
        end

        // IR and R observed through the bus.
        bus_sel = 4'd4; write_en = 0; inc_en = 0; clr_en = 0; alu_op = 0;
        #1 chk("ir_bus", dm_wdata, 16'h0003);
        bus_sel = 4'd6;
        #1 chk("r_bus", dm_wdata, 16'h0100);
        @(posedge clk); #1;

        // Store: dm_we only during the strobe cycle.
        bus_sel = 4'd5; write_en = 16'h0800;
        #1;
        chk("st_we", dm_we, 1'b1);
        chk("st_wdata", dm_wdata, 16'h0100);
        chk("st_addr", dm_addr, 16'h1234);
        @(posedge clk); #1;
        write_en = 16'h0000;
        #1 chk("st_we_off", dm_we, 1'b0);
        @(posedge clk); #1;

`ifdef DATAPATH_BUS_ERR_EN
        cycle(4'd14, 16'h0020, 16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h0000);
        chk("err_set", err, 1'b1);
        bus_sel = 4'd6; write_en = 0;
        #1 chk("err_r", dm_wdata, 16'h0000);
        repeat (3) @(posedge clk);
        #1 chk("err_sticky", err, 1'b1);
        // Restart the model from reset so the random phase can check err again.
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        @(posedge clk); #1;
`endif

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] imv;
            imv = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cycle(4'($urandom_range(0, 15)),
                  16'($urandom & $urandom), 16'($urandom & $urandom & $urandom),
                  16'($urandom & $urandom & $urandom & $urandom),
                  ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                  imv, 16'($urandom));
        end

        // Asynchronous reset mid-cycle with strobes held.
        bus_sel = 4'd13; write_en = 16'hFFFF; inc_en = 16'hFFFF; clr_en = 0; alu_op = 3'd0;
        im_rdata = 16'h1111;
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", im_addr, 16'h0010);
        chk("arst_ac", ac_out, 16'h0000);
        chk("arst_z", z_flag, 1'b1);
        @(posedge clk); #1;
        chk("arst_hold_pc", im_addr, 16'h0010);
        rst = 1'b0;
        model_reset();
        cycle(4'd0, 16'h0000, 16'h0002, 16'h0000, 3'd0, 16'h0000, 16'h0000);
        chk("post_rst_pc", im_addr, 16'h0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_bus.md
Name: datapath_bus

Overview:
- Datapath responder to the processor control FSM.
- Holds the architectural registers PC, AR, IR, AC, R, R1–R4 and the ALU.
- Drives the shared 16-bit internal bus from the register selected by bus_sel.
- Executes per-cycle write, increment and clear strobes, and returns the zero flag to the controller.
- Fronts the external instruction memory (IM) and data memory (DM).

Parameters:
- DATA_W, 16, width of every register, the bus and memory data.
- PC_RESET, 0, value loaded into PC on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- bus_sel  in  4  bus source select, encoding below
- write_en  in  16  per-register load strobes from bus
- inc_en  in  16  per-register increment strobes
- clr_en  in  16  per-register clear strobes
- alu_op  in  3  0 none, 1 add, 2 sub, 3 mult, 4 lshift
- im_addr  out  DATA_W  equals PC
- im_rdata  in  DATA_W  instruction word, combinational from im_addr
- dm_addr  out  DATA_W  equals AR
- dm_wdata  out  DATA_W  equals bus
- dm_we  out  1  equals write_en[11]
- dm_rdata  in  DATA_W  data word, combinational from dm_addr
- z_flag  out  1  registered AC==0 flag
- ac_out  out  DATA_W  AC value, for observation
- err  out  1  present only with the optional feature

Behaviour:
- Strobe bit map (write_en / inc_en / clr_en): 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1, 11 DM (write_en only).
- Unused bits 0, 6 and 12–15 are ignored.
- bus_sel codes:
  - 0 → bus = 0
  - 1 PC, 2 AR, 4 IR, 5 AC, 6 R, 7 R1, 8 R2, 9 R3, 10 R4
  - 12 dm_rdata, 13 im_rdata
  - Others (3, 11, 14, 15) → 0
- Bus is combinational. A register load samples the bus on the same edge, so there is one cycle of latency from strobe to new value.
- Per-register priority on each edge: clr > ALU result (AC only) > bus load > increment.
- Increment wraps: 0xFFFF+1 = 0x0000.
- Multiple registers may load from the bus in the same cycle.
- A register may load from itself, including AC from bus_sel 5.
- ALU, when alu_op is nonzero, writes AC at the next edge:
  - add: AC+R, low DATA_W bits
  - sub: AC−R, two's-complement wrap
  - mult: low DATA_W bits of AC*R
  - lshift: AC<<1, zero fill
  - alu_op 5–7: no operation
- z_flag:
  - Updated on every edge where AC changes (clr, ALU, load, inc).
  - Value equals (next AC == 0).
  - Otherwise holds.
- Reset (asynchronous, any time including mid-instruction):
  - PC=PC_RESET; AR, IR, AC, R, R1–R4 = 0; z_flag=1; err=0.
  - dm_we follows write_en, so the integrating design must hold write_en low while rst is asserted.
  - After rst deasserts, the first rising edge performs normal updates.
- No internal state machine beyond register updates. Sequencing belongs to the controller.

Optional Feature:
- Macro: DATAPATH_BUS_ERR_EN.
- Defined: err port exists and is a sticky flag, set on the edge after either of:
  - any write_en bit in {1,2,3,4,5,7,8,9,10,11} set while bus_sel is an undefined code;
  - alu_op nonzero while write_en[4] or clr_en[4] is set.
- The offending update still executes per the normal rules.
- err is cleared only by rst.
- Not defined: no err port; behaviour otherwise identical.

Test Plan:
- Reset value: assert rst with PC_RESET=0x0010 → PC=0x0010, im_addr=0x0010, AC=0, z_flag=1. Strobes applied during rst are ignored.
- Fetch: im_rdata=0x0003, bus_sel=13, write_en[3]=1; next cycle inc_en[1]=1 → IR=0x0003, PC increments by 1.
- Load and store:
  - AC=0x1234, bus_sel=5, write_en[2] → AR=0x1234, dm_addr=0x1234.
  - Then bus_sel=5, write_en[11] → dm_we=1, dm_wdata=0x1234 for exactly one cycle.
- ALU:
  - AC=5, R=7, alu_op=2 → AC=0xFFFE, z_flag=0.
  - Then AC=0x8001, alu_op=4 → AC=0x0002.
  - AC=0x0100, R=0x0100, alu_op=3 → AC=0x0000, z_flag=1.
- Priority and wrap:
  - AC=0xFFFF, inc_en[4] → AC=0, z_flag=1.
  - Same cycle clr_en[1] and write_en[1] with bus=0x55 → PC=0.
- Error flag (with DATAPATH_BUS_ERR_EN): bus_sel=14 with write_en[5] → R=0, err=1 and remains 1 until rst.
